button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 20 ++
 rtl/button_event_arbiter_evt_fifo.sv | 64 ++++++
 rtl/button_event_arbiter.sv | 128 ++++++++++++
 tb/tb_button_event_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button event arbiter.
//   EVT_W         : width of an event byte
//   EMPTY_CODE    : byte returned when a read finds the event FIFO empty
//   N_BTN_DEFAULT : default number of button inputs
//   DEPTH_DEFAULT : default number of event FIFO entries
//   CNT_W         : width of the evt_count output
package button_event_arbiter_pkg;

  localparam int EVT_W = 8;
  localparam logic [EVT_W-1:0] EMPTY_CODE = 8'hFF;
  localparam int N_BTN_DEFAULT = 4;
  localparam int DEPTH_DEFAULT = 4;
  localparam int CNT_W = 5;

  // Event byte for a granted button: button index in the low three bits.
  function automatic logic [EVT_W-1:0] evt_code(input logic [2:0] idx);
    return {{(EVT_W-3){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/button_event_arbiter_evt_fifo.sv
// evt_fifo: circular event queue with show-ahead head output.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write din at the tail
//   pop        : drop the head
//   dout       : current head entry (valid while !empty)
//   count      : entries held (0..DEPTH)
//   full/empty : count == DEPTH / count == 0
//
// Handshake: push is accepted when !full, or when full and an accepted pop
// occurs in the same cycle (the freed slot is reused at the same edge).
// pop is accepted only when !empty. Requests that are not accepted are
// silently ignored and change no state.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: collects one-cycle button event pulses into pending
// bits, grants them round-robin into an event FIFO and serves byte reads.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_evt    : one-cycle event pulse per button
//   rd_en      : read strobe; answer appears on rd_data/rd_valid next cycle
//   clr_ovf    : clears the sticky overflow flag (a same-cycle set wins)
//   rd_data    : head event byte, or EMPTY_CODE when read while empty; held
//   rd_valid   : one-cycle pulse following each rd_en
//   irq        : registered "FIFO not empty"
//   evt_count  : events currently queued
//   ovf        : sticky, set when a button event was coalesced/lost
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_evt,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [EVT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             irq,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf
);

  logic [N_BTN-1:0]        pending;
  logic [2:0]              rr_ptr;
  logic [2:0]              rr_next;
  logic [3:0]              g_plus1;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [EVT_W-1:0]        head;
  logic                    pop;
  logic                    can_push;
  logic                    hi_vld;
  logic                    lo_vld;
  logic [2:0]              hi_idx;
  logic [2:0]              lo_idx;
  logic                    grant_vld;
  logic [2:0]              grant_idx;
  logic [N_BTN-1:0]        grant_oh;
  logic                    ovf_set;

  assign pop      = rd_en & ~fifo_empty;
  // A full FIFO still takes a push when the same cycle frees the head slot.
  assign can_push = ~fifo_full | pop;

  // Round-robin pick: lowest pending index at or above rr_ptr, otherwise
  // wrap to the lowest pending index overall. The loop runs downwards so
  // the last hit is the lowest index.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_vld = 1'b1;
        lo_idx = 3'(i);
        if (3'(i) >= rr_ptr) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end
      end
    end
  end

  assign grant_vld = lo_vld & can_push;
  assign grant_idx = hi_vld ? hi_idx : lo_idx;

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_BTN; i++) begin
      grant_oh[i] = grant_vld && (grant_idx == 3'(i));
    end
  end

  // An event on a button that is granted this cycle is a fresh event and
  // re-arms pending; on any other pending button it is coalesced (lost).
  assign ovf_set = |(btn_evt & pending & ~grant_oh);

  assign g_plus1 = {1'b0, grant_idx} + 4'd1;
  assign rr_next = (g_plus1 >= 4'(N_BTN)) ? 3'd0 : g_plus1[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      rr_ptr   <= '0;
      ovf      <= 1'b0;
      irq      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= EMPTY_CODE;
    end else begin
      pending  <= (pending & ~grant_oh) | btn_evt;
      if (grant_vld) rr_ptr <= rr_next;
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      irq      <= (fifo_count != '0);
      rd_valid <= rd_en;
      // The head is sampled before any same-cycle push lands, so an empty
      // FIFO answers EMPTY_CODE even when a grant is writing this cycle.
      if (rd_en) rd_data <= pop ? head : EMPTY_CODE;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_evt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_vld),
    .pop   (pop),
    .din   (evt_code(grant_idx)),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_count = CNT_W'(fifo_count);

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_evt;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       irq;
  logic [4:0] evt_count;
  logic       ovf;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  button_event_arbiter #(.N_BTN(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_evt   (btn_evt),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .irq       (irq),
    .evt_count (evt_count),
    .ovf       (ovf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    btn_evt = '0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    rst_n   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  // ---------------- drivers ----------------
  task automatic pulse(input logic [3:0] m);
    btn_evt = m;
    @(posedge clk);
    #1;
    btn_evt = '0;
  endtask

  task automatic read_once();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    btn_evt = 4'b1111;
    rd_en   = 1'b1;
    clr_ovf = 1'b0;
    idle(2);
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL reset_rd_data: got %h expected ff", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    btn_evt = '0;
    rd_en   = 1'b0;
    rst_n   = 1'b1;
    idle(3);
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL reset_ignored_count: got %0d expected 0", evt_count); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_ignored_irq: got %b expected 0", irq); end
  endtask

  task automatic test_single();
    apply_reset();
    pulse(4'b0100);
    idle(1);
    checks++; if (evt_count !== 5'd1) begin failures++; $display("FAIL single_count_t1: got %0d expected 1", evt_count); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_t1: got %b expected 0", irq); end
    idle(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL single_irq_t2: got %b expected 1", irq); end
    checks++; if (evt_count !== 5'd1) begin failures++; $display("FAIL single_count_t2: got %0d expected 1", evt_count); end
    read_once();
    checks++; if (rd_data !== 8'h02) begin failures++; $display("FAIL single_rd_data: got %h expected 02", rd_data); end
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL single_count_after_read: got %0d expected 0", evt_count); end
    idle(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_clear: got %b expected 0", irq); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_rd_valid_pulse: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'h02) begin failures++; $display("FAIL single_rd_data_hold: got %h expected 02", rd_data); end
  endtask

  task automatic test_all_buttons();
    logic [7:0] exp;
    apply_reset();
    pulse(4'b1111);
    idle(4);
    checks++; if (evt_count !== 5'd4) begin failures++; $display("FAIL all_count: got %0d expected 4", evt_count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL all_ovf: got %b expected 0", ovf); end
    exp_q = {8'h00, 8'h01, 8'h02, 8'h03};
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      read_once();
      checks++; if (rd_data !== exp || rd_valid !== 1'b1) begin failures++; $display("FAIL all_read: got %h/%b expected %h/1", rd_data, rd_valid, exp); end
    end
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL all_count_end: got %0d expected 0", evt_count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL all_ovf_end: got %b expected 0", ovf); end
  endtask

  task automatic test_full_overflow();
    logic [7:0] exp;
    apply_reset();
    pulse(4'b1111);
    idle(4);
    pulse(4'b0010);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fullovf_first_pulse_ovf: got %b expected 0", ovf); end
    pulse(4'b0010);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL fullovf_ovf: got %b expected 1", ovf); end
    idle(2);
    checks++; if (evt_count !== 5'd4) begin failures++; $display("FAIL fullovf_count_held: got %0d expected 4", evt_count); end
    read_once();
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL fullovf_first_read: got %h expected 00", rd_data); end
    checks++; if (evt_count !== 5'd4) begin failures++; $display("FAIL fullovf_count_refill: got %0d expected 4", evt_count); end
    exp_q = {8'h01, 8'h02, 8'h03, 8'h01};
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      read_once();
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL fullovf_read: got %h expected %h", rd_data, exp); end
    end
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL fullovf_count_end: got %0d expected 0", evt_count); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL fullovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_empty_read();
    apply_reset();
    read_once();
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL empty_rd_data: got %h expected ff", rd_data); end
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL empty_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL empty_count: got %0d expected 0", evt_count); end
    idle(1);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL empty_rd_valid_pulse: got %b expected 0", rd_valid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL empty_irq: got %b expected 0", irq); end
  endtask

  task automatic test_empty_grant_read();
    apply_reset();
    pulse(4'b0001);
    // Grant of button 0 and rd_en land on the same edge with the FIFO empty.
    read_once();
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL nobypass_rd_data: got %h expected ff", rd_data); end
    checks++; if (evt_count !== 5'd1) begin failures++; $display("FAIL nobypass_count: got %0d expected 1", evt_count); end
    read_once();
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL nobypass_second_read: got %h expected 00", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    apply_reset();
    pulse(4'b1111);
    idle(4);
    pulse(4'b1100);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf_pre: got %b expected 0", ovf); end
    // Pop 00, grant 02 into the freed slot, button 3 coalesces while clr_ovf is high.
    rd_en   = 1'b1;
    btn_evt = 4'b1000;
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    rd_en   = 1'b0;
    btn_evt = '0;
    clr_ovf = 1'b0;
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL b2b_rd_data: got %h expected 00", rd_data); end
    checks++; if (evt_count !== 5'd4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", evt_count); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL b2b_set_wins: got %b expected 1", ovf); end
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_clr_ovf: got %b expected 0", ovf); end
    exp_q = {8'h01, 8'h02, 8'h03, 8'h02, 8'h03};
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      read_once();
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL b2b_read: got %h expected %h", rd_data, exp); end
    end
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL b2b_count_end: got %0d expected 0", evt_count); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    pulse(4'b1111);
    idle(4);
    pulse(4'b0001);
    pulse(4'b0001);
    read_once();
    read_once();
    checks++; if (rd_data !== 8'h01 || evt_count !== 5'd3) begin failures++; $display("FAIL areset_pre: got %h/%0d expected 01/3", rd_data, evt_count); end
    checks++; if (irq !== 1'b1 || ovf !== 1'b1 || rd_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_flags: got irq=%b ovf=%b vld=%b expected 1/1/1", irq, ovf, rd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL areset_rd_data: got %h expected ff", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL areset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL areset_irq: got %b expected 0", irq); end
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL areset_count: got %0d expected 0", evt_count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL areset_ovf: got %b expected 0", ovf); end
    btn_evt = 4'b1111;
    rd_en   = 1'b1;
    repeat (2) @(posedge clk);
    btn_evt = '0;
    rd_en   = 1'b0;
    #1;
    rst_n = 1'b1;
    idle(3);
    checks++; if (evt_count !== 5'd0) begin failures++; $display("FAIL areset_post_count: got %0d expected 0", evt_count); end
    read_once();
    checks++; if (rd_data !== 8'hFF || rd_valid !== 1'b1) begin failures++; $display("FAIL areset_post_read: got %h/%b expected ff/1", rd_data, rd_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    btn_evt  = '0;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_single();
    test_all_buttons();
    test_full_overflow();
    test_empty_read();
    test_empty_grant_read();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
